// File: rtl/jpegls_pipe_pkg.sv
// Shared definitions for the JPEG-LS inter-stage register bank.
// - Context payload field widths and packing offsets (LSB-relative).
// - stage_payload_t: packed view of the DATA_W payload word.
// - PAYLOAD_W: payload width, derived as the sum of the field widths.
// - Control-lane bit indices for the never-stalling control signals.
package jpegls_pipe_pkg;

  localparam int Q_W      = 9;
  localparam int A_W      = 10;
  localparam int B_W      = 7;
  localparam int C_W      = 7;
  localparam int N_W      = 6;
  localparam int NN_W     = 6;
  localparam int TEMP_W   = 4;
  localparam int J_W      = 5;
  localparam int RESID_W  = 8;
  localparam int MODE_W   = 1;
  localparam int RUN_ST_W = 1;

  localparam int PAYLOAD_W = Q_W + A_W + B_W + C_W + N_W + NN_W + TEMP_W
                           + J_W + RESID_W + MODE_W + RUN_ST_W;

  localparam int OFF_RUN_ST = 0;
  localparam int OFF_MODE   = OFF_RUN_ST + RUN_ST_W;
  localparam int OFF_RESID  = OFF_MODE   + MODE_W;
  localparam int OFF_J      = OFF_RESID  + RESID_W;
  localparam int OFF_TEMP   = OFF_J      + J_W;
  localparam int OFF_NN     = OFF_TEMP   + TEMP_W;
  localparam int OFF_N      = OFF_NN     + NN_W;
  localparam int OFF_C      = OFF_N      + N_W;
  localparam int OFF_B      = OFF_C      + C_W;
  localparam int OFF_A      = OFF_B      + B_W;
  localparam int OFF_Q      = OFF_A      + A_W;

  // Field order matches the offsets above: q is the MSB field.
  typedef struct packed {
    logic [Q_W-1:0]      q;
    logic [A_W-1:0]      a;
    logic [B_W-1:0]      b;
    logic [C_W-1:0]      c;
    logic [N_W-1:0]      n;
    logic [NN_W-1:0]     nn;
    logic [TEMP_W-1:0]   temp;
    logic [J_W-1:0]      j;
    logic [RESID_W-1:0]  residual;
    logic [MODE_W-1:0]   mode;
    logic [RUN_ST_W-1:0] run_st;
  } stage_payload_t;

  localparam int CTRL_LANE_W     = 3;
  localparam int CTRL_START_ENC  = 0;
  localparam int CTRL_DO_RUN_ENC = 1;
  localparam int CTRL_DO_RUN_ADJ = 2;

endpackage

// File: rtl/jpegls_skid_fifo2.sv
// Two-entry input skid FIFO.
// - push_*: upstream side; push_ready depends only on the count register
//   (and reset), so there is no combinational path from pop_ready.
// - pop_*: head entry, feeds pipeline stage 0.
// - flush empties the FIFO; entry contents are left as don't-care.
module jpegls_skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [1:0]   count;
  logic [W-1:0] ent0, ent1;
  logic         push, pop;

  // A pop while full does not reopen the input until the next cycle.
  assign push_ready = reset && (count != 2'd2);
  assign push       = push_valid && push_ready;
  assign pop_valid  = (count != 2'd0);
  assign pop        = pop_valid && pop_ready;
  assign pop_data   = ent0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      if (pop) begin
        if (count == 2'd2)  ent0 <= ent1;
        else if (push)      ent0 <= push_data;
      end else if (push) begin
        if (count == 2'd0)  ent0 <= push_data;
        else                ent1 <= push_data;
      end
      if (flush) count <= 2'd0;
      else       count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/jpegls_pipe_stage.sv
// Flow-controlled inter-stage register bank for the JPEG-LS encoder.
// - in_*: valid/ready payload input with eof and an ungated control lane.
// - out_*: head beat of the pipe; out_ctrl is in_ctrl delayed DEPTH cycles.
// - flush: drops every in-flight beat, including one handshaked this cycle.
// - occupancy: beats held in skid + stages; eof_done: registered pulse one
//   cycle after an eof beat leaves.
module jpegls_pipe_stage
  import jpegls_pipe_pkg::*;
#(
  parameter int DATA_W = PAYLOAD_W,
  parameter int CTRL_W = CTRL_LANE_W,
  parameter int DEPTH  = 2,
  parameter int SKID   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_eof,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_eof,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [$clog2(DEPTH+3)-1:0]   occupancy,
  output logic                         eof_done
);

  localparam int OCC_W = $clog2(DEPTH+3);

  logic [DEPTH:0]                  rdy;
  logic [DEPTH-1:0]                vld_pipe;
  logic [DEPTH-1:0][DATA_W-1:0]    dat_pipe;
  logic [DEPTH-1:0]                eof_pipe;
  logic [DEPTH-1:0][CTRL_W-1:0]    ctrl_pipe;

  logic              s0_valid, s0_eof;
  logic [DATA_W-1:0] s0_data;
  logic              accept, emit;

  // ---- stage-0 source: skid FIFO head or the raw input ----
  if (SKID != 0) begin : g_skid
    logic [DATA_W:0] head;
    jpegls_skid_fifo2 #(.W(DATA_W+1)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push_valid(in_valid),
      .push_ready(in_ready),
      .push_data ({in_eof, in_data}),
      .pop_valid (s0_valid),
      .pop_ready (rdy[0]),
      .pop_data  (head)
    );
    assign s0_eof  = head[DATA_W];
    assign s0_data = head[DATA_W-1:0];
  end else begin : g_noskid
    assign in_ready = reset && rdy[0];
    assign s0_valid = in_valid;
    assign s0_data  = in_data;
    assign s0_eof   = in_eof;
  end

  // ---- bubble-collapsing payload stages ----
  assign rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic              src_v, src_e, v_q, e_q;
    logic [DATA_W-1:0] src_d, d_q;

    if (i == 0) begin : g_first
      assign src_v = s0_valid;
      assign src_d = s0_data;
      assign src_e = s0_eof;
    end else begin : g_next
      assign src_v = vld_pipe[i-1];
      assign src_d = dat_pipe[i-1];
      assign src_e = eof_pipe[i-1];
    end

    assign rdy[i] = !v_q || rdy[i+1];

    always_ff @(posedge clk) begin
      if (!reset) begin
        v_q <= 1'b0;
        d_q <= '0;
        e_q <= 1'b0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (rdy[i]) begin
        v_q <= src_v;
        d_q <= src_d;
        e_q <= src_e;
      end
    end

    assign vld_pipe[i] = v_q;
    assign dat_pipe[i] = d_q;
    assign eof_pipe[i] = e_q;
  end

  assign out_valid = vld_pipe[DEPTH-1];
  assign out_data  = dat_pipe[DEPTH-1];
  assign out_eof   = eof_pipe[DEPTH-1];

  // ---- control lane: advances every cycle, blind to handshake/flush ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_pipe <= '0;
    end else begin
      ctrl_pipe[0] <= in_ctrl;
      for (int i = 1; i < DEPTH; i++) ctrl_pipe[i] <= ctrl_pipe[i-1];
    end
  end
  assign out_ctrl = ctrl_pipe[DEPTH-1];

  // ---- occupancy and eof drain pulse ----
  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      occupancy <= '0;
      eof_done  <= 1'b0;
    end else begin
      if (flush) occupancy <= '0;
      else       occupancy <= occupancy + {{(OCC_W-1){1'b0}}, accept}
                                        - {{(OCC_W-1){1'b0}}, emit};
      // The beat has left the pipe, so flush does not cancel the pulse.
      eof_done <= emit && out_eof;
    end
  end

endmodule

// File: tb/tb_jpegls_pipe_stage.sv
module tb_jpegls_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_eof, flush;
  logic [63:0] in_data;
  logic [2:0]  in_ctrl;
  logic        out_valid, out_ready, out_eof;
  logic [63:0] out_data;
  logic [2:0]  out_ctrl;
  logic [2:0]  occupancy;
  logic        eof_done;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  jpegls_pipe_stage #(.DATA_W(64), .CTRL_W(3), .DEPTH(2), .SKID(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_eof(in_eof), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_eof(out_eof), .out_ctrl(out_ctrl), .occupancy(occupancy),
    .eof_done(eof_done)
  );

  typedef struct {
    string       name;
    logic        v;
    logic [63:0] d;
    logic        e;
    logic [2:0]  c;
    logic        fl;
    logic        ordy;
    logic        x_irdy;
    logic        x_ov;
    logic [63:0] x_od;
    logic        x_oe;
    logic [2:0]  x_oc;
    logic [2:0]  x_occ;
    logic        x_eofd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic v, logic [63:0] d, logic e,
                              logic [2:0] c, logic fl, logic ordy,
                              logic x_irdy, logic x_ov, logic [63:0] x_od,
                              logic x_oe, logic [2:0] x_oc, logic [2:0] x_occ,
                              logic x_eofd);
    vec_t r;
    r.name = name; r.v = v; r.d = d; r.e = e; r.c = c; r.fl = fl;
    r.ordy = ordy; r.x_irdy = x_irdy; r.x_ov = x_ov; r.x_od = x_od;
    r.x_oe = x_oe; r.x_oc = x_oc; r.x_occ = x_occ; r.x_eofd = x_eofd;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [63:0] d, logic e, logic [2:0] c,
                       logic fl, logic ordy);
    in_valid = v; in_data = d; in_eof = e; in_ctrl = c;
    flush = fl; out_ready = ordy;
  endtask

  initial begin
    //            name     v  d       e  c     fl ordy irdy ov od      oe oc    occ eofd
    // streaming, out_ready=1
    vecs.push_back(mk("a0", 1, 64'h11, 0, 3'd0, 0, 1,  1,  0, 64'h0,  0, 3'd0, 3'd1, 0));
    vecs.push_back(mk("a1", 1, 64'h22, 0, 3'd0, 0, 1,  1,  0, 64'h0,  0, 3'd0, 3'd2, 0));
    vecs.push_back(mk("a2", 1, 64'h33, 0, 3'd0, 0, 1,  1,  1, 64'h11, 0, 3'd0, 3'd3, 0));
    vecs.push_back(mk("a3", 0, 64'h0,  0, 3'd0, 0, 1,  1,  1, 64'h22, 0, 3'd0, 3'd2, 0));
    vecs.push_back(mk("a4", 0, 64'h0,  0, 3'd0, 0, 1,  1,  1, 64'h33, 0, 3'd0, 3'd1, 0));
    vecs.push_back(mk("a5", 0, 64'h0,  0, 3'd0, 0, 1,  1,  0, 64'h0,  0, 3'd0, 3'd0, 0));
    // fill to capacity with out_ready=0, then drain
    vecs.push_back(mk("b0", 1, 64'hA1, 0, 3'd0, 0, 0,  1,  0, 64'h0,  0, 3'd0, 3'd1, 0));
    vecs.push_back(mk("b1", 1, 64'hA2, 0, 3'd0, 0, 0,  1,  0, 64'h0,  0, 3'd0, 3'd2, 0));
    vecs.push_back(mk("b2", 1, 64'hA3, 0, 3'd0, 0, 0,  1,  1, 64'hA1, 0, 3'd0, 3'd3, 0));
    vecs.push_back(mk("b3", 1, 64'hA4, 0, 3'd0, 0, 0,  0,  1, 64'hA1, 0, 3'd0, 3'd4, 0));
    vecs.push_back(mk("b4", 1, 64'hA5, 0, 3'd0, 0, 0,  0,  1, 64'hA1, 0, 3'd0, 3'd4, 0));
    vecs.push_back(mk("b5", 0, 64'h0,  0, 3'd0, 0, 1,  1,  1, 64'hA2, 0, 3'd0, 3'd3, 0));
    vecs.push_back(mk("b6", 0, 64'h0,  0, 3'd0, 0, 1,  1,  1, 64'hA3, 0, 3'd0, 3'd2, 0));
    vecs.push_back(mk("b7", 0, 64'h0,  0, 3'd0, 0, 1,  1,  1, 64'hA4, 0, 3'd0, 3'd1, 0));
    vecs.push_back(mk("b8", 0, 64'h0,  0, 3'd0, 0, 1,  1,  0, 64'h0,  0, 3'd0, 3'd0, 0));
    // eof beat and drain pulse
    vecs.push_back(mk("c0", 1, 64'hAB, 1, 3'd0, 0, 1,  1,  0, 64'h0,  0, 3'd0, 3'd1, 0));
    vecs.push_back(mk("c1", 0, 64'h0,  0, 3'd0, 0, 1,  1,  0, 64'h0,  0, 3'd0, 3'd1, 0));
    vecs.push_back(mk("c2", 0, 64'h0,  0, 3'd0, 0, 1,  1,  1, 64'hAB, 1, 3'd0, 3'd1, 0));
    vecs.push_back(mk("c3", 0, 64'h0,  0, 3'd0, 0, 1,  1,  0, 64'h0,  0, 3'd0, 3'd0, 1));
    vecs.push_back(mk("c4", 0, 64'h0,  0, 3'd0, 0, 1,  1,  0, 64'h0,  0, 3'd0, 3'd0, 0));
    // control lane while stalled
    vecs.push_back(mk("d0", 0, 64'h0,  0, 3'b101, 0, 0, 1, 0, 64'h0,  0, 3'd0,   3'd0, 0));
    vecs.push_back(mk("d1", 0, 64'h0,  0, 3'd0,   0, 0, 1, 0, 64'h0,  0, 3'b101, 3'd0, 0));
    vecs.push_back(mk("d2", 0, 64'h0,  0, 3'd0,   0, 0, 1, 0, 64'h0,  0, 3'd0,   3'd0, 0));
    // flush with a concurrent handshake
    vecs.push_back(mk("e0", 1, 64'hC1, 0, 3'd0,   0, 0, 1, 0, 64'h0,  0, 3'd0,   3'd1, 0));
    vecs.push_back(mk("e1", 1, 64'hC2, 0, 3'd0,   0, 0, 1, 0, 64'h0,  0, 3'd0,   3'd2, 0));
    vecs.push_back(mk("e2", 1, 64'hC3, 0, 3'd0,   0, 0, 1, 1, 64'hC1, 0, 3'd0,   3'd3, 0));
    vecs.push_back(mk("e3", 1, 64'hC4, 0, 3'b110, 1, 0, 1, 0, 64'h0,  0, 3'd0,   3'd0, 0));
    vecs.push_back(mk("e4", 0, 64'h0,  0, 3'd0,   0, 1, 1, 0, 64'h0,  0, 3'b110, 3'd0, 0));
    vecs.push_back(mk("e5", 0, 64'h0,  0, 3'd0,   0, 1, 1, 0, 64'h0,  0, 3'd0,   3'd0, 0));
    vecs.push_back(mk("e6", 0, 64'h0,  0, 3'd0,   0, 1, 1, 0, 64'h0,  0, 3'd0,   3'd0, 0));

    // ---- reset state ----
    reset = 1'b0;
    drive(0, 64'h0, 0, 3'd0, 0, 1);
    step(); step();
    chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_occ",       {61'd0, occupancy}, 64'd0);
    chk("rst_eof_done",  {63'd0, eof_done},  64'd0);
    chk("rst_out_ctrl",  {61'd0, out_ctrl},  64'd0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready",  {63'd0, in_ready},  64'd1);

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].e, vecs[i].c, vecs[i].fl, vecs[i].ordy);
      step();
      chk({vecs[i].name, "_in_ready"},  {63'd0, in_ready},  {63'd0, vecs[i].x_irdy});
      chk({vecs[i].name, "_out_valid"}, {63'd0, out_valid}, {63'd0, vecs[i].x_ov});
      if (vecs[i].x_ov) begin
        chk({vecs[i].name, "_out_data"}, out_data,           vecs[i].x_od);
        chk({vecs[i].name, "_out_eof"},  {63'd0, out_eof},   {63'd0, vecs[i].x_oe});
      end
      chk({vecs[i].name, "_out_ctrl"},  {61'd0, out_ctrl},  {61'd0, vecs[i].x_oc});
      chk({vecs[i].name, "_occ"},       {61'd0, occupancy}, {61'd0, vecs[i].x_occ});
      chk({vecs[i].name, "_eof_done"},  {63'd0, eof_done},  {63'd0, vecs[i].x_eofd});
    end

    // ---- mid-stream reset with 3 beats in flight ----
    drive(1, 64'hD1, 1, 3'd0, 0, 0); step();
    drive(1, 64'hD2, 0, 3'd0, 0, 0); step();
    drive(1, 64'hD3, 0, 3'b111, 0, 0); step();
    chk("pre_rst_occ", {61'd0, occupancy}, 64'd3);
    reset = 1'b0;
    drive(0, 64'h0, 0, 3'd0, 0, 1);
    step();
    chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_out_data",  out_data,           64'd0);
    chk("mrst_out_eof",   {63'd0, out_eof},   64'd0);
    chk("mrst_out_ctrl",  {61'd0, out_ctrl},  64'd0);
    chk("mrst_occ",       {61'd0, occupancy}, 64'd0);
    chk("mrst_eof_done",  {63'd0, eof_done},  64'd0);
    chk("mrst_in_ready",  {63'd0, in_ready},  64'd0);
    reset = 1'b1;
    drive(1, 64'hE1, 0, 3'd0, 0, 1);
    #1;
    chk("mrel_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("mrel_first_accept_occ", {61'd0, occupancy}, 64'd1);
    drive(0, 64'h0, 0, 3'd0, 0, 1);
    step();
    step();
    chk("mrel_out_valid", {63'd0, out_valid}, 64'd1);
    chk("mrel_out_data",  out_data,           64'h00000000000000E1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jpegls_pipe_stage.md
# jpegls_pipe_stage

Parametrised, flow-controlled inter-stage register bank for the JPEG-LS encoder datapath. It replaces fixed, enable-gated stage register banks with a `DEPTH`-deep pipeline that carries a packed context payload: Q, A, B, C, N, Nn, temp, J, residual, mode, run state and similar fields. It adds a valid/ready handshake, a 2-entry input skid buffer, flush, occupancy tracking and an EOF-drain pulse. An always-advancing control lane carries the signals that must never stall, such as start_enc, do_run_encoding and do_run_length_adjust.

## Interface
Parameters:
- `DATA_W`, 64: packed payload width; gated, handshaked lane.
- `CTRL_W`, 3: ungated control lane width.
- `DEPTH`, 2: payload register stages, ≥1.
- `SKID`, 1: 1 = 2-entry input skid buffer present; 0 = none.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low; 0 = reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_data`  in  DATA_W  payload.
- `in_eof`  in  1  beat is last of image.
- `in_ctrl`  in  CTRL_W  ungated control.
- `flush`  in  1  drop all in-flight beats.
- `out_valid`  out  1  downstream beat valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  DATA_W  payload.
- `out_eof`  out  1  eof of head beat.
- `out_ctrl`  out  CTRL_W  `in_ctrl` delayed DEPTH cycles.
- `occupancy`  out  $clog2(DEPTH+3)  beats held, skid + stages.
- `eof_done`  out  1  one-cycle pulse, registered.

## Operation
- Reset (`reset`=0 at edge): clears all valid bits, data, eof, ctrl and skid entries. `occupancy`=0, `eof_done`=0, `out_valid`=0. `in_ready`=0 while `reset`=0.
- Skid (`SKID`=1): 2-entry FIFO in front of stage 0.
  - `in_ready` = (skid count != 2), decoded from registers only. No combinational path from `out_ready` to `in_ready`.
  - The head entry feeds stage 0.
  - When count=2, a pop in the same cycle does not raise `in_ready` until the next cycle (one-bubble rule).
- `SKID`=0: `in_ready` = `ready_0`.
- Stage advance is bubble-collapsing:
  - `ready_i` = !`valid_i` || `ready_(i+1)`; `ready_DEPTH` = `out_ready`.
  - Stage i loads data/eof/valid from stage i-1 when `ready_i`.
  - A stalled stage holds its value.
- Control lane: a shift register of DEPTH flops, enabled every cycle. It ignores handshake and flush; only `reset` clears it.
- Flush has priority over every advance.
  - All valid bits and the skid count are cleared at the edge. Data is retained as don't-care.
  - A beat handshaked in the flush cycle is discarded.
  - `occupancy` becomes 0 next cycle.
- `occupancy` is registered and updates by +accept −emit per cycle; accept and emit in the same cycle leave it unchanged.
- `eof_done` = 1 for one cycle after any edge where `out_valid && out_ready && out_eof`, and is not suppressed by flush.

## Timing
- Latency with no stall: in→out = DEPTH+SKID cycles. Beat accepted at edge t is at `out_valid` after edge t+DEPTH+SKID−1.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- Capacity = DEPTH+2·SKID beats. With `out_ready`=0 and continuous `in_valid`, `in_ready` falls after exactly DEPTH+2·SKID accepts.
- `out_ctrl` latency is fixed at DEPTH cycles, independent of stalls.
- Reset released mid-stream: the first accept can occur in the first cycle with `reset`=1.

## Structure
- Payload field widths come from the existing `Parameterize_JPEGLS.v` constants.
- Shared package `jpegls_pipe_pkg` holds:
  - the payload packing offsets and a `stage_payload_t` packed struct;
  - `DATA_W` derived as the sum of field widths;
  - the ctrl bit indices `CTRL_START_ENC`, `CTRL_DO_RUN_ENC`, `CTRL_DO_RUN_ADJ`.
- Sub-module `jpegls_skid_fifo2`, a 2-entry FIFO with count and registered ready, instantiated under `SKID`=1.
- The stage array is a generate loop.

## Test plan
- DEPTH=2, SKID=1, `out_ready`=1, beats 0x11,0x22,0x33 on consecutive cycles → `out_data` 0x11,0x22,0x33 on consecutive cycles. First out is 2 cycles after first accept; `occupancy` peaks at 3.
- `out_ready`=0, continuous `in_valid` → exactly 4 accepts, then `in_ready`=0 and `occupancy`=4. Raise `out_ready` → 4 beats emerge in order, and `in_ready` returns 1 cycle later.
- Pipe holding 3 beats, `flush`=1 with `in_valid`=1 in the same cycle → next cycle `occupancy`=0, `out_valid`=0, and the flushed beats never appear. `out_ctrl` keeps shifting.
- Beat 0xAB with `in_eof`=1 → `out_eof`=1 with 0xAB; `eof_done` pulses exactly once, one cycle after the handshake.
- `in_ctrl`=3'b101 for one cycle while `out_ready`=0 → `out_ctrl`=3'b101 exactly DEPTH cycles later.
- `reset`=0 for one edge with 3 beats in flight → all outputs 0 next cycle and `in_ready`=1 once `reset`=1.
